// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared definitions for the forwarding / hazard scoreboard:
// register address width, scoreboard slot layout and select encodings.
package fwd_pkg;
    localparam int REG_ADDR_W = 5;

    // Forwarding select encoding: 0 = register file / ID value, k = stage k after EX
    localparam int SEL_RF  = 0;
    localparam int SEL_MEM = 1;
    localparam int SEL_WB  = 2;

    // One in-flight destination; valid only for real writes to a non-zero rd
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } slot_t;

    // A destination is worth tracking only when it is written and is not x0
    function automatic logic tracks_rd(input logic w_en, input logic [REG_ADDR_W-1:0] rd);
        return w_en && (rd != '0);
    endfunction
endpackage

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// Per-source hazard resolution: finds the youngest scoreboard slot that
// writes this source and turns it into a forwarding select, a load-use
// stall request, or a write-during-read register-file bypass.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  logic [FWD_STAGES:0]                  slot_valid_i,
    input  logic [(FWD_STAGES+1)*REG_ADDR_W-1:0] slot_rd_i,
    input  logic [FWD_STAGES:0]                  slot_load_i,
    input  logic [REG_ADDR_W-1:0]                rs_addr_i,
    input  logic                                 rs_used_i,
    output logic [SEL_W-1:0]                     sel_o,
    output logic                                 stall_req_o,
    output logic                                 bypass_o
);
    logic hit;
    int   hit_s;
    logic hit_load;

    // Priority search: scan oldest to youngest so the lowest matching slot wins
    always_comb begin
        hit      = 1'b0;
        hit_s    = 0;
        hit_load = 1'b0;
        for (int s = FWD_STAGES; s >= 0; s--) begin
            if (rs_used_i && (rs_addr_i != '0) && slot_valid_i[s] &&
                (slot_rd_i[s*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i)) begin
                hit      = 1'b1;
                hit_s    = s;
                hit_load = slot_load_i[s];
            end
        end
    end

    // The match sits one stage further on when ID reaches EX; forward it from
    // there unless it is a load whose data is not ready yet. A match in the
    // last slot is being written to the RF right now, so the RF path covers it.
    always_comb begin
        sel_o       = SEL_W'(SEL_RF);
        stall_req_o = 1'b0;
        if (hit && (hit_s < FWD_STAGES)) begin
            if (hit_load && (hit_s + 1 < 1 + LOAD_LAT))
                stall_req_o = 1'b1;
            else
                sel_o = SEL_W'(hit_s + 1);
        end
    end

    assign bypass_o = rs_used_i && slot_valid_i[FWD_STAGES] &&
                      (slot_rd_i[FWD_STAGES*REG_ADDR_W +: REG_ADDR_W] == rs_addr_i);
endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding / hazard scoreboard beside the ID/EX register. Tracks the
// destination of every instruction from EX through FWD_STAGES later stages
// and produces EX-aligned forwarding selects, a load-use stall and an ID
// register-file bypass. Define FWD_HAZARD_PERF_EN to add saturating stall
// and forward event counters with a synchronous clear.
module fwd_hazard_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NUM_RS     = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int LOAD_LAT   = 1,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         id_valid_i,
    input  logic [REG_ADDR_W*NUM_RS-1:0] id_rs_addr_i,
    input  logic [NUM_RS-1:0]            id_rs_used_i,
    input  logic [REG_ADDR_W-1:0]        id_rd_addr_i,
    input  logic                         id_reg_w_en_i,
    input  logic                         id_is_load_i,
    input  logic                         hold_i,
    input  logic                         flush_i,
`ifdef FWD_HAZARD_PERF_EN
    input  logic                         perf_clr_i,
    output logic [31:0]                  perf_stall_cnt_o,
    output logic [31:0]                  perf_fwd_cnt_o,
`endif
    output logic                         stall_out_o,
    output logic [SEL_W*NUM_RS-1:0]      fwd_sel_o,
    output logic [NUM_RS-1:0]            rf_bypass_o
);
    slot_t [FWD_STAGES:0]                 slot_q, slot_d;
    logic  [FWD_STAGES:0]                 slot_valid;
    logic  [(FWD_STAGES+1)*REG_ADDR_W-1:0] slot_rd;
    logic  [FWD_STAGES:0]                 slot_load;
    logic  [SEL_W*NUM_RS-1:0]             sel_nxt, fwd_sel_q, fwd_sel_d;
    logic  [NUM_RS-1:0]                   stall_req;
    logic                                 issue;

    for (genvar s = 0; s <= FWD_STAGES; s++) begin : g_flat
        assign slot_valid[s]                         = slot_q[s].valid;
        assign slot_rd[s*REG_ADDR_W +: REG_ADDR_W]   = slot_q[s].rd;
        assign slot_load[s]                          = slot_q[s].is_load;
    end

    for (genvar i = 0; i < NUM_RS; i++) begin : g_src
        fwd_src_match #(
            .FWD_STAGES (FWD_STAGES),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .slot_valid_i (slot_valid),
            .slot_rd_i    (slot_rd),
            .slot_load_i  (slot_load),
            .rs_addr_i    (id_rs_addr_i[i*REG_ADDR_W +: REG_ADDR_W]),
            .rs_used_i    (id_rs_used_i[i]),
            .sel_o        (sel_nxt[i*SEL_W +: SEL_W]),
            .stall_req_o  (stall_req[i]),
            .bypass_o     (rf_bypass_o[i])
        );
    end

    // A redirect kills the ID instruction, so it can never be stalled
    assign stall_out_o = id_valid_i && (|stall_req) && !flush_i;
    assign issue       = id_valid_i && !stall_out_o && !flush_i;

    // Shift the scoreboard and capture ID into EX; under hold only a flush
    // may act, and then it just kills whatever sits in EX
    always_comb begin
        slot_d    = slot_q;
        fwd_sel_d = fwd_sel_q;
        if (!hold_i) begin
            for (int s = FWD_STAGES; s > 0; s--)
                slot_d[s] = slot_q[s-1];
            slot_d[0] = '0;
            fwd_sel_d = '0;
            if (issue) begin
                slot_d[0].valid   = tracks_rd(id_reg_w_en_i, id_rd_addr_i);
                slot_d[0].rd      = id_rd_addr_i;
                slot_d[0].is_load = id_is_load_i;
                fwd_sel_d         = sel_nxt;
            end
        end else if (flush_i) begin
            slot_d[0] = '0;
            fwd_sel_d = '0;
        end
    end

    // Scoreboard and EX-aligned select registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_q    <= '0;
            fwd_sel_q <= '0;
        end else begin
            slot_q    <= slot_d;
            fwd_sel_q <= fwd_sel_d;
        end
    end

    assign fwd_sel_o = fwd_sel_q;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_fwd_q;

    // Saturating event counters: real stall cycles and forwarded issues
    always_ff @(posedge clk_i) begin
        if (rst_i || perf_clr_i) begin
            perf_stall_q <= '0;
            perf_fwd_q   <= '0;
        end else begin
            if (stall_out_o && !hold_i && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (!hold_i && issue && (|sel_nxt) && (perf_fwd_q != '1))
                perf_fwd_q <= perf_fwd_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_fwd_cnt_o   = perf_fwd_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: a default instance (2 sources, 2 forward
// stages, load latency 1) and a wide one (3 sources, 3 stages, latency 2),
// directed instruction streams, and a reference model that tracks in-flight
// writers by age and re-derives every output each cycle.
module tb_fwd_hazard_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   go  = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, indexed by instance (0 = default, 1 = wide)
    bit         iv[2], iw[2], il[2], ih[2], ifl[2];
    logic [4:0] ird[2];
    logic [4:0] ia[2][3];
    bit         iu[2][3];

    logic       st0, st1;
    logic [3:0] fs0;
    logic [5:0] fs1;
    logic [1:0] by0;
    logic [2:0] by1;

    fwd_hazard_scoreboard #(.NUM_RS(2), .FWD_STAGES(2), .LOAD_LAT(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(iv[0]),
        .id_rs_addr_i({ia[0][1], ia[0][0]}), .id_rs_used_i({iu[0][1], iu[0][0]}),
        .id_rd_addr_i(ird[0]), .id_reg_w_en_i(iw[0]), .id_is_load_i(il[0]),
        .hold_i(ih[0]), .flush_i(ifl[0]),
        .stall_out_o(st0), .fwd_sel_o(fs0), .rf_bypass_o(by0)
    );

    fwd_hazard_scoreboard #(.NUM_RS(3), .FWD_STAGES(3), .LOAD_LAT(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .id_valid_i(iv[1]),
        .id_rs_addr_i({ia[1][2], ia[1][1], ia[1][0]}),
        .id_rs_used_i({iu[1][2], iu[1][1], iu[1][0]}),
        .id_rd_addr_i(ird[1]), .id_reg_w_en_i(iw[1]), .id_is_load_i(il[1]),
        .hold_i(ih[1]), .flush_i(ifl[1]),
        .stall_out_o(st1), .fwd_sel_o(fs1), .rf_bypass_o(by1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int nrs(input int k);    return (k == 0) ? 2 : 3; endfunction
    function automatic int fs_of(input int k);  return (k == 0) ? 2 : 3; endfunction
    function automatic int ll_of(input int k);  return (k == 0) ? 1 : 2; endfunction

    function automatic int dut_sel(input int k, input int i);
        return (k == 0) ? int'(fs0[i*2 +: 2]) : int'(fs1[i*2 +: 2]);
    endfunction
    function automatic int dut_byp(input int k, input int i);
        return (k == 0) ? int'(by0[i]) : int'(by1[i]);
    endfunction
    function automatic int dut_stall(input int k);
        return (k == 0) ? int'(st0) : int'(st1);
    endfunction

    // ---------------- reference model ----------------
    // Each tracked writer is remembered with its age: the number of stages
    // it has advanced past EX. Age > FWD_STAGES means it has retired.
    typedef struct {
        int         dut;
        int         age;
        logic [4:0] rd;
        bit         ld;
    } ent_t;
    ent_t fly[$];
    int   exp_sel[2][3];

    function automatic void src_exp(input int k, input int i,
                                    output int sel, output bit stl, output bit byp);
        int best;
        bit bld;
        sel = 0; stl = 0; byp = 0; best = -1; bld = 0;
        if (!iu[k][i] || ia[k][i] == 5'd0) return;
        foreach (fly[j]) begin
            if (fly[j].dut == k && fly[j].rd == ia[k][i]) begin
                if (best < 0 || fly[j].age < best) begin
                    best = fly[j].age;
                    bld  = fly[j].ld;
                end
                if (fly[j].age == fs_of(k)) byp = 1;
            end
        end
        if (best < 0 || best == fs_of(k)) return;
        // when ID reaches EX the writer is at stage best+1
        if (bld && (best + 1) < 1 + ll_of(k)) stl = 1;
        else sel = best + 1;
    endfunction

    function automatic bit exp_stall(input int k);
        int s;
        bit t, b, any;
        any = 0;
        for (int i = 0; i < nrs(k); i++) begin
            src_exp(k, i, s, t, b);
            any |= t;
        end
        return iv[k] && !ifl[k] && any;
    endfunction

    always @(posedge clk) begin : model
        ent_t nq[$];
        ent_t e;
        int   sn[2][3];
        bit   iss[2];
        bit   t, b;
        for (int k = 0; k < 2; k++) begin
            iss[k] = iv[k] && !ifl[k] && !exp_stall(k);
            for (int i = 0; i < 3; i++) begin
                sn[k][i] = 0;
                if (i < nrs(k)) src_exp(k, i, sn[k][i], t, b);
            end
        end
        nq = {};
        foreach (fly[j]) begin
            e = fly[j];
            if (rst) continue;
            if (ih[e.dut]) begin
                if (ifl[e.dut] && e.age == 0) continue;
            end else begin
                e.age++;
                if (e.age > fs_of(e.dut)) continue;
            end
            nq.push_back(e);
        end
        for (int k = 0; k < 2; k++)
            if (!rst && !ih[k] && iss[k] && iw[k] && ird[k] != 5'd0)
                nq.push_back('{k, 0, ird[k], il[k]});
        fly = nq;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 3; i++) begin
                if (rst) exp_sel[k][i] = 0;
                else if (ih[k]) begin
                    if (ifl[k]) exp_sel[k][i] = 0;
                end else exp_sel[k][i] = iss[k] ? sn[k][i] : 0;
            end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin : compare
        int s;
        bit t, b;
        if (go) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d.stall", k), dut_stall(k), int'(exp_stall(k)));
                for (int i = 0; i < nrs(k); i++) begin
                    src_exp(k, i, s, t, b);
                    chk($sformatf("m%0d.bypass[%0d]", k, i), dut_byp(k, i), int'(b));
                    chk($sformatf("m%0d.fwd_sel[%0d]", k, i), dut_sel(k, i), exp_sel[k][i]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input int k, input bit v, input int rd, input bit w, input bit l,
                       input int a0, input int a1, input int a2, input bit [2:0] u);
        @(posedge clk); #1;
        iv[k] = v; ird[k] = 5'(rd); iw[k] = w; il[k] = l;
        ia[k][0] = 5'(a0); ia[k][1] = 5'(a1); ia[k][2] = 5'(a2);
        iu[k][0] = u[0]; iu[k][1] = u[1]; iu[k][2] = u[2];
    endtask
    task automatic nops(input int k, input int n);
        repeat (n) drv(k, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; iw[k] = 0; il[k] = 0; ih[k] = 0; ifl[k] = 0; ird[k] = '0;
            for (int i = 0; i < 3; i++) begin ia[k][i] = '0; iu[k][i] = 0; end
        end
        tick(); tick();
        go = 1;
        at_neg();
        chk("reset.stall0", int'(st0), 0);
        chk("reset.fwd0", int'(fs0), 0);
        chk("reset.byp0", int'(by0), 0);
        chk("reset.fwd1", int'(fs1), 0);
        chk("reset.stall1", int'(st1), 0);
        tick(); rst = 0;

        // add x5 ; add x6,x5,x1 -> forward from MEM, no stall
        drv(0, 1, 5, 1, 0, 0, 0, 0, 3'b000);
        drv(0, 1, 6, 1, 0, 5, 1, 0, 3'b011);
        at_neg(); chk("alu.stall", int'(st0), 0);
        nops(0, 1);
        at_neg(); chk("alu.fwd", int'(fs0), 4'b0001);
        nops(0, 4);

        // lw x5 ; add x6,x5,x5 -> one stall cycle, then both from WB
        drv(0, 1, 5, 1, 1, 0, 0, 0, 3'b000);
        drv(0, 1, 6, 1, 0, 5, 5, 0, 3'b011);
        at_neg(); chk("lu.stall1", int'(st0), 1);
        tick();
        at_neg(); chk("lu.stall2", int'(st0), 0);
        nops(0, 1);
        at_neg(); chk("lu.fwd", int'(fs0), 4'b1010);
        nops(0, 4);

        // x7 written in WB while ID reads x7 -> RF bypass, select 0
        drv(0, 1, 7, 1, 0, 0, 0, 0, 3'b000);
        nops(0, 2);
        drv(0, 1, 8, 1, 0, 7, 0, 0, 3'b001);
        at_neg(); chk("byp.bypass", int'(by0), 2'b01);
        nops(0, 1);
        at_neg(); chk("byp.fwd", int'(fs0), 0);
        nops(0, 4);

        // x0 is never tracked
        drv(0, 1, 0, 1, 0, 0, 0, 0, 3'b000);
        drv(0, 1, 9, 1, 0, 0, 0, 0, 3'b011);
        at_neg(); chk("x0.stall", int'(st0), 0);
        nops(0, 1);
        at_neg(); chk("x0.fwd", int'(fs0), 0);

        // two writers of x3 in flight -> younger (MEM) wins
        drv(0, 1, 3, 1, 0, 0, 0, 0, 3'b000);
        drv(0, 1, 3, 1, 0, 0, 0, 0, 3'b000);
        drv(0, 1, 4, 1, 0, 3, 3, 0, 3'b011);
        nops(0, 1);
        at_neg(); chk("young.fwd", int'(fs0), 4'b0101);
        nops(0, 4);

        // load-use with flush in the same cycle -> no stall, bubble
        drv(0, 1, 5, 1, 1, 0, 0, 0, 3'b000);
        drv(0, 1, 6, 1, 0, 5, 0, 0, 3'b001); ifl[0] = 1;
        at_neg(); chk("flush.stall", int'(st0), 0);
        nops(0, 1); ifl[0] = 0;
        at_neg(); chk("flush.fwd", int'(fs0), 0);
        nops(0, 4);

        // hold for 3 cycles in the middle of a load-use stall
        drv(0, 1, 4, 1, 0, 0, 0, 0, 3'b000);
        drv(0, 1, 5, 1, 1, 4, 0, 0, 3'b001);
        drv(0, 1, 6, 1, 0, 5, 0, 0, 3'b001); ih[0] = 1;
        at_neg(); chk("hold.stall0", int'(st0), 1); chk("hold.fwd0", int'(fs0), 4'b0001);
        repeat (2) begin
            tick();
            at_neg(); chk("hold.stall", int'(st0), 1); chk("hold.fwd", int'(fs0), 4'b0001);
        end
        tick(); ih[0] = 0;
        at_neg(); chk("hold.drop_stall", int'(st0), 1);
        tick();
        at_neg(); chk("hold.resolved", int'(st0), 0);
        nops(0, 1);
        at_neg(); chk("hold.fwd_after", int'(fs0), 4'b0010);
        nops(0, 4);

        // reset asserted mid-stall clears it on the next edge
        drv(0, 1, 5, 1, 1, 0, 0, 0, 3'b000);
        drv(0, 1, 6, 1, 0, 5, 0, 0, 3'b001); rst = 1;
        at_neg(); chk("rst.stall_before", int'(st0), 1);
        tick();
        at_neg(); chk("rst.stall_after", int'(st0), 0); chk("rst.fwd", int'(fs0), 0);
        tick(); rst = 0;
        nops(0, 2);

        // wide instance: lw x9 then a user of x9 on all three sources
        drv(1, 1, 9, 1, 1, 0, 0, 0, 3'b000);
        drv(1, 1, 10, 1, 0, 9, 9, 9, 3'b111);
        at_neg(); chk("wide.stall1", int'(st1), 1);
        tick();
        at_neg(); chk("wide.stall2", int'(st1), 1);
        tick();
        at_neg(); chk("wide.stall3", int'(st1), 0);
        nops(1, 1);
        at_neg(); chk("wide.fwd", int'(fs1), 6'b111111);
        nops(1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the combinational forwarding unit of the pipelined RV32I core.
- Tracks every in-flight destination register in its own shift-register scoreboard (EX plus FWD_STAGES later stages).
- Produces registered per-source forwarding selects aligned to EX, a load-use stall, and a same-cycle register-file bypass for ID.
- Sits beside the ID/EX pipeline register; the datapath muxes consume its selects.

Parameters:
NUM_RS, 2, number of source operands per instruction (rs1, rs2, ...)
FWD_STAGES, 2, stages after EX able to forward (1=MEM, 2=WB, ...); min 1
LOAD_LAT, 1, extra stages before a load result is forwardable; 0 to FWD_STAGES-1
SEL_W, $clog2(FWD_STAGES+1), width of each select field (derived, not overridden)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  5*NUM_RS  source addresses, field i = source i
id_rs_used  in  NUM_RS  source i is actually read (opcode-decoded upstream)
id_rd_addr  in  5  destination of ID instruction
id_reg_w_en  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
hold  in  1  external pipeline freeze (e.g. memory wait)
flush  in  1  kill ID and EX (branch redirect)
stall_out  out  1  load-use stall: freeze PC/IF/ID, inject bubble into EX
fwd_sel  out  SEL_W*NUM_RS  registered EX operand select: 0=RF/ID value, k=stage k result
rf_bypass  out  NUM_RS  combinational: source i takes last-stage write data at ID read

Behaviour:
- Scoreboard slots 0..FWD_STAGES (0=EX); each holds valid, rd, is_load. Valid is set only if reg_w_en and rd != 0.
- Each non-hold cycle, slots shift up by one; slot FWD_STAGES retires.
- Slot 0 loads the ID instruction if id_valid && !stall_out && !flush; otherwise it loads a bubble (valid=0).
- hold: all slots, fwd_sel and the stall state are frozen. hold has priority over stall_out and flush, except flush still clears slot 0 and the ID capture.
- Match rule: source i matches slot s when id_rs_used[i] and rd == addr and rd != 0. Only the youngest matching slot (lowest s) counts.
- Next-cycle position p = s+1. p is forwardable if p <= FWD_STAGES and (!is_load or p >= 1+LOAD_LAT).
- Youngest match forwardable: fwd_sel[i] <= p on the cycle ID issues into EX (1-cycle latency, aligned with EX).
- Youngest match not forwardable: stall_out=1 combinationally. Shifting continues, so the stall self-clears after exactly (1+LOAD_LAT)-p cycles.
- No match, or youngest match at slot FWD_STAGES (it writes the RF this cycle): fwd_sel[i] <= 0.
- rf_bypass[i] = 1 when slot FWD_STAGES is valid, its rd == addr and id_rs_used[i]. This covers the write-during-read case.
- Bubble or flush cycle: fwd_sel <= 0.
- Simultaneous stall and flush: flush wins, stall_out forced 0 that cycle.
- Reset: all slots invalid, fwd_sel=0, stall_out=0, rf_bypass=0 (counters 0 if enabled).
- Reset asserted mid-stall clears the stall on the next edge.
- rd=x0 is never tracked; sources reading x0 always select 0.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32), perf_fwd_cnt (32) and input perf_clr.
  - perf_stall_cnt increments each cycle with stall_out && !hold.
  - perf_fwd_cnt increments per issuing instruction with any nonzero select.
  - Both counters saturate at 2^32-1; perf_clr zeroes them synchronously.
- Undefined: no counters, ports absent, zero extra logic.

Decomposition:
- Shared package fwd_pkg: REG_ADDR_W=5, slot struct {valid, rd, is_load}, select encoding constants SEL_RF=0, SEL_MEM=1, SEL_WB=2.
- One natural sub-module: fwd_src_match, instantiated NUM_RS times. It performs the youngest-match priority search and returns the select, the stall request and the bypass for a single source.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> fwd_sel[0]=1 in EX of second add, stall_out never 1.
- lw x5 then add x6,x5,x5 (LOAD_LAT=1) -> stall_out=1 for exactly 1 cycle, then fwd_sel={2,2}.
- Instruction writing x7 in WB while ID reads x7 -> rf_bypass[0]=1 that cycle, next fwd_sel[0]=0.
- add x0,... then consumer of x0 -> fwd_sel=0, no stall; older add x3 and younger add x3 both in flight -> select = younger stage (1).
- lw-use stall with flush asserted same cycle -> stall_out=0, slot 0 bubble, fwd_sel=0; hold for 3 cycles mid-stall -> stall_out and fwd_sel frozen, stall resolves 1 cycle after hold drops.
- FWD_STAGES=3, LOAD_LAT=2, NUM_RS=3: lw x9 then three users of x9 -> 2 stall cycles, then fwd_sel=3 for all three sources.
